// File: rtl/maze_pkg.sv
// maze_pkg: shared types for the travel plan sequencer.
// Opcode and sequencer state enums plus small plan helpers.
package maze_pkg;

    typedef enum logic [1:0] {
        STOP        = 2'b00,
        VEER_R      = 2'b01,
        VEER_L      = 2'b10,
        TURN_AROUND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FOLLOW   = 2'd1,
        MANEUVER = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam int         PLAN_W  = 16;
    localparam logic [3:0] LAST_OP = 4'd7;

    // Opcode at the head of the plan (LSB pair executes first).
    function automatic op_t head_op(input logic [PLAN_W-1:0] plan);
        return op_t'(plan[1:0]);
    endfunction

endpackage

// File: rtl/bump_sync.sv
// bump_sync: two-flop synchronizers for the active-low bump switches.
// Ports: clk, rst (async high), bmp_l_n/bmp_r_n (raw pins),
//        bumped (high while either synchronized switch is pressed).
module bump_sync (
    input  logic clk,
    input  logic rst,
    input  logic bmp_l_n,
    input  logic bmp_r_n,
    output logic bumped
);

    logic [1:0] l_ff;
    logic [1:0] r_ff;

    // Flops idle at 1 so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_ff <= 2'b11;
            r_ff <= 2'b11;
        end else begin
            l_ff <= {l_ff[0], bmp_l_n};
            r_ff <= {r_ff[0], bmp_r_n};
        end
    end

    assign bumped = ~l_ff[1] | ~r_ff[1];

endmodule

// File: rtl/travel_plan_seq.sv
// travel_plan_seq: steps a robot through an 8-opcode travel plan,
// triggering one maneuver per debounced line gap.
// Ports: clk, rst (async high); cmd/cmd_rdy/clr_cmd_rdy plan load;
//        line_present, man_done, BMPL_n/BMPR_n inputs;
//        go, man_code, man_strt, buzz_en, plan_done outputs.
// Option: define BUMP_RECOVER_EN to resume automatically after an
//         obstruction has been clear for RESUME_CYC cycles.
module travel_plan_seq
    import maze_pkg::*;
#(
    parameter int GAP_DEB    = 4096,
    parameter int RESUME_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        line_present,
    input  logic        man_done,
    input  logic        BMPL_n,
    input  logic        BMPR_n,
    output logic        go,
    output logic [1:0]  man_code,
    output logic        man_strt,
    output logic        buzz_en,
    output logic        plan_done
);

    localparam int GAP_W = $clog2(GAP_DEB + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_DEB);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_DEB - 1);

    if (GAP_DEB < 1 || RESUME_CYC < 1) begin : g_param_chk
        $error("travel_plan_seq: GAP_DEB and RESUME_CYC must be >= 1");
    end

    state_t             state;
    logic [PLAN_W-1:0]  plan;
    logic [3:0]         op_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               bumped;
    logic               take_cmd;
    logic               moving;
    logic               gap_full;

`ifdef BUMP_RECOVER_EN
    localparam int RES_W = $clog2(RESUME_CYC + 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESUME_CYC - 1);

    // Only needed to know where to go back to after a resume.
    state_t             saved_state;
    logic [RES_W-1:0]   resume_cnt;
`endif

    bump_sync u_bump (
        .clk     (clk),
        .rst     (rst),
        .bmp_l_n (BMPL_n),
        .bmp_r_n (BMPR_n),
        .bumped  (bumped)
    );

    // A new plan is accepted when idle or when parked after a bump.
    assign take_cmd = cmd_rdy && (state == IDLE || state == HALT);
    assign moving   = (state == FOLLOW) || (state == MANEUVER);
    // This absent cycle is the GAP_DEB-th consecutive one.
    assign gap_full = (gap_cnt >= GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            plan        <= '0;
            op_cnt      <= '0;
            gap_cnt     <= '0;
            go          <= 1'b0;
            man_code    <= 2'b00;
            man_strt    <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            buzz_en     <= 1'b0;
            plan_done   <= 1'b0;
`ifdef BUMP_RECOVER_EN
            saved_state <= IDLE;
            resume_cnt  <= '0;
`endif
        end else begin
            man_strt    <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            plan_done   <= 1'b0;

            if (take_cmd) begin
                plan        <= cmd;
                op_cnt      <= '0;
                gap_cnt     <= '0;
                clr_cmd_rdy <= 1'b1;
                go          <= 1'b1;
                buzz_en     <= 1'b0;
                state       <= FOLLOW;
            end else if (bumped && moving) begin
                go      <= 1'b0;
                buzz_en <= 1'b1;
                state   <= HALT;
`ifdef BUMP_RECOVER_EN
                saved_state <= state;
                resume_cnt  <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    FOLLOW: begin
                        if (line_present) begin
                            gap_cnt <= '0;
                        end else begin
                            if (gap_cnt != GAP_MAX)
                                gap_cnt <= gap_cnt + 1'b1;
                            if (gap_full) begin
                                if (head_op(plan) == STOP) begin
                                    go        <= 1'b0;
                                    plan_done <= 1'b1;
                                    state     <= IDLE;
                                end else begin
                                    man_code <= plan[1:0];
                                    man_strt <= 1'b1;
                                    state    <= MANEUVER;
                                end
                            end
                        end
                    end
                    MANEUVER: begin
                        if (man_done) begin
                            plan    <= {2'b00, plan[PLAN_W-1:2]};
                            op_cnt  <= op_cnt + 1'b1;
                            gap_cnt <= '0;
                            if (op_cnt == LAST_OP) begin
                                go        <= 1'b0;
                                plan_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                state <= FOLLOW;
                            end
                        end
                    end
                    HALT: begin
`ifdef BUMP_RECOVER_EN
                        // Any press restarts the release count.
                        if (bumped) begin
                            resume_cnt <= '0;
                        end else if (resume_cnt == RES_LAST) begin
                            resume_cnt <= '0;
                            buzz_en    <= 1'b0;
                            go         <= 1'b1;
                            state      <= saved_state;
                        end else begin
                            resume_cnt <= resume_cnt + 1'b1;
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_travel_plan_seq.sv
// tb_travel_plan_seq: self-checking bench for travel_plan_seq.
// Directed scenarios plus random traffic against a queue-based model.
module tb_travel_plan_seq;

    localparam int GAP = 16;
    localparam int RES = 32;

    localparam int PH_IDLE   = 0;
    localparam int PH_FOLLOW = 1;
    localparam int PH_MAN    = 2;
    localparam int PH_HALT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        cmd_rdy = 1'b0;
    logic        line_present = 1'b1;
    logic        man_done = 1'b0;
    logic        BMPL_n = 1'b1;
    logic        BMPR_n = 1'b1;
    logic        clr_cmd_rdy;
    logic        go;
    logic [1:0]  man_code;
    logic        man_strt;
    logic        buzz_en;
    logic        plan_done;

    travel_plan_seq #(
        .GAP_DEB    (GAP),
        .RESUME_CYC (RES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .line_present (line_present),
        .man_done     (man_done),
        .BMPL_n       (BMPL_n),
        .BMPR_n       (BMPR_n),
        .go           (go),
        .man_code     (man_code),
        .man_strt     (man_strt),
        .buzz_en      (buzz_en),
        .plan_done    (plan_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: remaining opcodes as a queue, plus simple counters.
    int ops[$];
    int phase;
    int saved_ph;
    int absent;
    int rel;
    bit h1, h2;
    bit e_go, e_buzz, e_strt, e_done, e_clr;
    int e_code;

    // Observations for literal expectations.
    int obs_codes[$];
    int n_done_obs;
    int n_clr_obs;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ops.delete();
        phase    = PH_IDLE;
        saved_ph = PH_IDLE;
        absent   = 0;
        rel      = 0;
        h1       = 1'b0;
        h2       = 1'b0;
        e_go     = 1'b0;
        e_buzz   = 1'b0;
        e_strt   = 1'b0;
        e_done   = 1'b0;
        e_clr    = 1'b0;
        e_code   = 0;
    endtask

    task automatic model_load();
        int c;
        c = int'(cmd);
        ops.delete();
        for (int i = 0; i < 8; i++) ops.push_back((c >> (2 * i)) & 3);
        absent = 0;
        e_clr  = 1'b1;
        e_go   = 1'b1;
        e_buzz = 1'b0;
        phase  = PH_FOLLOW;
    endtask

    task automatic model_halt();
        saved_ph = phase;
        phase    = PH_HALT;
        e_go     = 1'b0;
        e_buzz   = 1'b1;
        rel      = 0;
    endtask

    task automatic model_step();
        bit bumped;
        if (rst) begin
            model_reset();
            return;
        end
        // A press reaches the sequencer two samples after the pin.
        bumped = h2;
        h2 = h1;
        h1 = !BMPL_n || !BMPR_n;
        e_clr  = 1'b0;
        e_strt = 1'b0;
        e_done = 1'b0;
        if (cmd_rdy && (phase == PH_IDLE || phase == PH_HALT)) begin
            model_load();
        end else if (bumped &&
                     (phase == PH_FOLLOW || phase == PH_MAN)) begin
            model_halt();
        end else if (phase == PH_FOLLOW) begin
            if (line_present) begin
                absent = 0;
            end else begin
                absent++;
                if (absent >= GAP) begin
                    if (ops[0] == 0) begin
                        e_go   = 1'b0;
                        e_done = 1'b1;
                        phase  = PH_IDLE;
                    end else begin
                        e_code = ops[0];
                        e_strt = 1'b1;
                        phase  = PH_MAN;
                    end
                end
            end
        end else if (phase == PH_MAN) begin
            if (man_done) begin
                void'(ops.pop_front());
                absent = 0;
                if (ops.size() == 0) begin
                    e_go   = 1'b0;
                    e_done = 1'b1;
                    phase  = PH_IDLE;
                end else begin
                    phase = PH_FOLLOW;
                end
            end
        end else if (phase == PH_HALT) begin
`ifdef BUMP_RECOVER_EN
            if (bumped) begin
                rel = 0;
            end else begin
                rel++;
                if (rel == RES) begin
                    rel    = 0;
                    e_buzz = 1'b0;
                    e_go   = 1'b1;
                    phase  = saved_ph;
                end
            end
`endif
        end
    endtask

    // One clock: advance the model on the edge, compare 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("go", go, e_go);
        chk("buzz_en", buzz_en, e_buzz);
        chk("man_strt", man_strt, e_strt);
        chk("plan_done", plan_done, e_done);
        chk("clr_cmd_rdy", clr_cmd_rdy, e_clr);
        if (e_strt || phase == PH_MAN)
            chk("man_code", man_code, e_code);
        if (man_strt) obs_codes.push_back(int'(man_code));
        if (plan_done) n_done_obs++;
        if (clr_cmd_rdy) n_clr_obs++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_rdy = 1'b0;
        line_present = 1'b1;
        man_done = 1'b0;
        BMPL_n = 1'b1;
        BMPR_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        obs_codes.delete();
        n_done_obs = 0;
        n_clr_obs = 0;
    endtask

    task automatic load_plan(input logic [15:0] c);
        cmd = c;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
    endtask

    // Hold the line absent until a maneuver or plan end shows up.
    task automatic run_gap(input bit ack);
        bit got;
        got = 1'b0;
        line_present = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (man_strt || plan_done) begin
                got = 1'b1;
                break;
            end
        end
        line_present = 1'b1;
        chk("gap_timeout", got, 1);
        if (got && man_strt && ack) begin
            man_done = 1'b1;
            tick();
            man_done = 1'b0;
        end
    endtask

    function automatic int code_at(input int i);
        return (i < obs_codes.size()) ? obs_codes[i] : -1;
    endfunction

    initial begin
        int at;
        int n3;
        int run_left;
        int bump_left;
        int which;

        model_reset();
        do_reset();

        // Reset state.
        chk("rst_go", go, 0);
        chk("rst_man_code", man_code, 0);
        chk("rst_buzz", buzz_en, 0);

        // Load 5555, then a 20-cycle gap.
        load_plan(16'h5555);
        chk("load_clr", clr_cmd_rdy, 1);
        chk("load_go", go, 1);
        tick();
        chk("clr_one_cycle", clr_cmd_rdy, 0);
        line_present = 1'b0;
        at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (man_strt && at == 0) at = i;
        end
        chk("strt_after_16", at, 16);
        chk("first_code", code_at(0), 1);
        chk("go_in_man", go, 1);

        // 15 absent, one present, 15 absent: never a maneuver.
        line_present = 1'b1;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        obs_codes.delete();
        for (int r = 0; r < 2; r++) begin
            line_present = 1'b0;
            repeat (15) tick();
            line_present = 1'b1;
            tick();
        end
        chk("no_strt_15", obs_codes.size(), 0);

        // 002D: 01, 11, 10 then stop.
        do_reset();
        load_plan(16'h002D);
        for (int g = 0; g < 4; g++) run_gap(1'b1);
        chk("seq_len", obs_codes.size(), 3);
        chk("seq0", code_at(0), 1);
        chk("seq1", code_at(1), 3);
        chk("seq2", code_at(2), 2);
        chk("stop_done", n_done_obs, 1);
        chk("stop_go", go, 0);

        // FFFF: eight turn-arounds then plan_done.
        do_reset();
        load_plan(16'hFFFF);
        for (int g = 0; g < 8; g++) run_gap(1'b1);
        n3 = 0;
        foreach (obs_codes[i]) if (obs_codes[i] == 3) n3++;
        chk("ffff_strts", n3, 8);
        chk("ffff_done", n_done_obs, 1);
        chk("ffff_go", go, 0);

        // Reset in the middle of a maneuver.
        load_plan(16'hFFFF);
        run_gap(1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_go", go, 0);
        chk("async_strt", man_strt, 0);
        chk("async_code", man_code, 0);
        chk("async_buzz", buzz_en, 0);
        chk("async_done", plan_done, 0);
        chk("async_clr", clr_cmd_rdy, 0);
        n_done_obs = 0;
        obs_codes.delete();
        tick();
        rst = 1'b0;
        line_present = 1'b0;
        repeat (20) tick();
        line_present = 1'b1;
        chk("discard_strt", obs_codes.size(), 0);
        chk("discard_done", n_done_obs, 0);

        // Bump while idle is ignored.
        do_reset();
        BMPL_n = 1'b0;
        repeat (5) tick();
        chk("idle_bump_buzz", buzz_en, 0);
        BMPL_n = 1'b1;
        repeat (3) tick();

        // Bump during FOLLOW.
        load_plan(16'h5555);
        repeat (3) tick();
        BMPR_n = 1'b0;
        at = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (!go && buzz_en && at == 0) at = i;
        end
        chk("halt_in_3", (at >= 1 && at <= 3), 1);
        BMPR_n = 1'b1;
`ifdef BUMP_RECOVER_EN
        at = 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (go && at == 0) at = i;
        end
        chk("resume_at_34", at, 34);
        chk("resume_buzz", buzz_en, 0);
        obs_codes.delete();
        run_gap(1'b1);
        chk("resume_code", code_at(0), 1);
`else
        repeat (40) tick();
        chk("stay_halted_go", go, 0);
        chk("stay_halted_buzz", buzz_en, 1);
        load_plan(16'h5555);
        chk("halt_reload_go", go, 1);
        chk("halt_reload_buzz", buzz_en, 0);
        chk("halt_reload_clr", clr_cmd_rdy, 1);
`endif

        // Random traffic against the model.
        run_left = 0;
        bump_left = 0;
        which = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (run_left == 0) begin
                line_present = ($urandom_range(0, 1) == 0);
                run_left = $urandom_range(1, 30);
            end else begin
                run_left--;
            end
            cmd_rdy  = ($urandom_range(0, 24) == 0);
            cmd      = 16'($urandom());
            man_done = ($urandom_range(0, 5) == 0);
            if (bump_left > 0) begin
                bump_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                bump_left = $urandom_range(1, 8);
                which = $urandom_range(0, 1);
            end
            BMPL_n = !(bump_left > 0 && which == 0);
            BMPR_n = !(bump_left > 0 && which == 1);
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 1'b0;
        cmd_rdy = 1'b0;
        man_done = 1'b0;
        BMPL_n = 1'b1;
        BMPR_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/travel_plan_seq.md
TRAVEL_PLAN_SEQ -- requirements
Module: travel_plan_seq

Interface
REQ-001 SHALL have parameter GAP_DEB, default 4096: consecutive line-absent cycles required to recognise a gap.
REQ-002 SHALL have parameter RESUME_CYC, default 65536: consecutive bump-released cycles before resuming (BUMP_RECOVER_EN only).
REQ-003 SHALL have port clk, input, 1: system clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port cmd, input, 16: travel plan of eight 2-bit opcodes, LSB pair first.
REQ-006 SHALL have port cmd_rdy, input, 1: level, a new plan is valid on cmd (from UART wrapper).
REQ-007 SHALL have port clr_cmd_rdy, output, 1: one-cycle pulse acknowledging plan capture.
REQ-008 SHALL have port line_present, input, 1: line sensed under robot.
REQ-009 SHALL have port man_done, input, 1: one-cycle pulse from steering stage, maneuver complete.
REQ-010 SHALL have ports BMPL_n and BMPR_n, input, 1 each: asynchronous active-low bump switches.
REQ-011 SHALL have port go, output, 1: motors enabled / follow line.
REQ-012 SHALL have port man_code, output, 2: current opcode; valid while man_strt or in MANEUVER.
REQ-013 SHALL have port man_strt, output, 1: one-cycle pulse starting a maneuver.
REQ-014 SHALL have port buzz_en, output, 1: piezo enable during obstruction.
REQ-015 SHALL have port plan_done, output, 1: one-cycle pulse when the plan terminates.

Function
REQ-016 SHALL decode opcodes as 00 stop, 01 veer right, 10 veer left, 11 turn around.
REQ-017 SHALL implement states IDLE, FOLLOW, MANEUVER, HALT.
REQ-018 IDLE with cmd_rdy=1 SHALL load cmd into the plan register, clear op_cnt, pulse clr_cmd_rdy, and assert go from the next cycle in FOLLOW.
REQ-019 cmd_rdy outside IDLE (HALT excepted, REQ-026) SHALL be ignored with no clr_cmd_rdy pulse.
REQ-020 FOLLOW SHALL count consecutive line_present=0 cycles; a cycle with line_present=1 clears the count; the counter saturates at GAP_DEB.
REQ-021 On reaching GAP_DEB with plan[1:0]=00, SHALL deassert go, pulse plan_done, and enter IDLE in the next cycle.
REQ-022 On reaching GAP_DEB with a non-zero opcode, SHALL drive man_code=plan[1:0], pulse man_strt for one cycle, and enter MANEUVER; go stays 1.
REQ-023 In MANEUVER, man_done SHALL shift the plan right by 2, increment op_cnt, clear the gap counter, and return to FOLLOW.
REQ-024 When op_cnt reaches 8, SHALL deassert go, pulse plan_done, and enter IDLE.
REQ-025 A synchronized bump (either low) in FOLLOW or MANEUVER SHALL enter HALT within 3 cycles of the pin falling: go=0, buzz_en=1, and the prior state saved; bumps in IDLE SHALL be ignored.
REQ-026 Without BUMP_RECOVER_EN, HALT SHALL persist until cmd_rdy=1, which loads a new plan as in REQ-018 and clears buzz_en.
REQ-027 man_done arriving in HALT SHALL be ignored.

Reset
REQ-028 rst SHALL immediately force IDLE; plan, op_cnt, gap and resume counters to 0; go, man_strt, clr_cmd_rdy, buzz_en, plan_done to 0; man_code to 00; bump synchronizer flops to 1.
REQ-029 rst mid-maneuver SHALL discard the plan; no plan_done pulse.

Configuration
REQ-030 Macro BUMP_RECOVER_EN defined: in HALT, after both bumps are released for RESUME_CYC consecutive cycles, SHALL clear buzz_en, set go=1, and return to the saved state with plan and op_cnt intact; any re-press restarts the count.
REQ-031 BUMP_RECOVER_EN undefined: the resume counter SHALL NOT exist; behaviour per REQ-026.

Structure
REQ-032 Package maze_pkg SHALL hold the opcode enum (STOP, VEER_R, VEER_L, TURN_AROUND) and the state enum.
REQ-033 Sub-module bump_sync SHALL provide a two-flop synchronizer per bump and a combined active-high "bumped" output.

Verification (GAP_DEB=16, RESUME_CYC=32)
REQ-034 cmd=16'h5555 with cmd_rdy, 20-cycle gap -> clr_cmd_rdy pulse, go=1, man_strt with man_code=01 after the 16th absent cycle.
REQ-035 cmd=16'h002D with four gaps and man_done after each -> man_code sequence 01, 11, 10; 4th gap gives plan_done, go=0.
REQ-036 Line absent for 15 cycles then present -> no man_strt, counter cleared.
REQ-037 BMPR_n=0 during FOLLOW -> go=0, buzz_en=1 within 3 cycles; with the macro, release for 32 cycles -> go=1 and the plan continues; without it, stays halted until cmd_rdy.
REQ-038 cmd=16'hFFFF, eight gaps with man_done -> eight man_strt with 11, then plan_done; rst asserted mid-MANEUVER -> all outputs 0 immediately.
